// File: rtl/regfile_mp.sv
// regfile_mp : parametrised multi-port integer register file
//
// Sits between decode (reads, issue marking) and writeback (writes,
// scoreboard release).  Holds DEPTH registers of DATA_W bits, a busy
// scoreboard bit per register, and a sequenced clear engine used for
// pipeline flush and context reset.
//
// Ports:
//   clk       in   clock, all state changes on the rising edge
//   rst       in   synchronous reset, active-high
//   raddr     in   NR read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rdata     out  NR read data words, same packing as raddr
//   rbusy     out  scoreboard busy bit for each read address
//   wen       in   NW write enables
//   waddr     in   NW write addresses
//   wdata     in   NW write data words
//   iss_en    in   mark iss_addr busy (destination issued)
//   iss_addr  in   destination register being issued
//   clr_req   in   request a full clear (only honoured when idle)
//   clr_busy  out  high while the clear engine runs
//   clr_done  out  one-cycle pulse on the final clear cycle
//
// Build option:
//   RF_BYPASS_EN  when defined, a read whose address matches a same-cycle
//                 accepted write returns that write's data (highest-index
//                 port wins) and reports not-busy.  When undefined, reads
//                 come only from the stored array.
//
// FSM states:
//   state    | meaning
//   ST_IDLE  | normal operation, writes and issues accepted
//   ST_CLEAR | zeroing one register per cycle, external writes/issues ignored

module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int NR       = 3,
  parameter int NW       = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NR*ADDR_W-1:0] raddr,
  output logic [NR*DATA_W-1:0] rdata,
  output logic [NR-1:0]        rbusy,
  input  logic [NW-1:0]        wen,
  input  logic [NW*ADDR_W-1:0] waddr,
  input  logic [NW*DATA_W-1:0] wdata,
  input  logic                 iss_en,
  input  logic [ADDR_W-1:0]    iss_addr,
  input  logic                 clr_req,
  output logic                 clr_busy,
  output logic                 clr_done
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];
  logic [DEPTH-1:0]    busy_q, busy_d;

  // Address 0 is architecturally constant when ZERO_REG is set.
  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Clear engine sequencing
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clr_busy = 1'b0;
    clr_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        clr_busy = 1'b1;
        cnt_d    = cnt_q + ADDR_W'(1);
        if (cnt_q == LAST_ADDR) begin
          clr_done = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Array and scoreboard update.  Ports are applied in ascending order so
  // the highest-index port wins a same-address collision, and the issue
  // set is applied last so a new producer supersedes a releasing write.
  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    if (state_q == ST_CLEAR) begin
      mem_d[cnt_q]  = '0;
      busy_d[cnt_q] = 1'b0;
    end else begin
      for (int j = 0; j < NW; j++) begin
        if (wen[j] && !is_zero_reg(waddr[j*ADDR_W +: ADDR_W])) begin
          mem_d[waddr[j*ADDR_W +: ADDR_W]]  = wdata[j*DATA_W +: DATA_W];
          busy_d[waddr[j*ADDR_W +: ADDR_W]] = 1'b0;
        end
      end
      if (iss_en && !is_zero_reg(iss_addr)) begin
        busy_d[iss_addr] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Combinational read ports
  always_comb begin
    rdata = '0;
    rbusy = '0;
    for (int k = 0; k < NR; k++) begin
      if (!is_zero_reg(raddr[k*ADDR_W +: ADDR_W])) begin
        rdata[k*DATA_W +: DATA_W] = mem_q[raddr[k*ADDR_W +: ADDR_W]];
        rbusy[k]                  = busy_q[raddr[k*ADDR_W +: ADDR_W]];
`ifdef RF_BYPASS_EN
        for (int j = 0; j < NW; j++) begin
          if ((state_q == ST_IDLE) && wen[j] &&
              !is_zero_reg(waddr[j*ADDR_W +: ADDR_W]) &&
              (waddr[j*ADDR_W +: ADDR_W] == raddr[k*ADDR_W +: ADDR_W])) begin
            rdata[k*DATA_W +: DATA_W] = wdata[j*DATA_W +: DATA_W];
            rbusy[k]                  = 1'b0;
          end
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;
  localparam int NR     = 3;
  localparam int NW     = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NR*ADDR_W-1:0] raddr;
  logic [NR*DATA_W-1:0] rdata;
  logic [NR-1:0]        rbusy;
  logic [NW-1:0]        wen;
  logic [NW*ADDR_W-1:0] waddr;
  logic [NW*DATA_W-1:0] wdata;
  logic                 iss_en;
  logic [ADDR_W-1:0]    iss_addr;
  logic                 clr_req;
  logic                 clr_busy;
  logic                 clr_done;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: plain arrays plus clear-engine progress
  logic [DATA_W-1:0] m_mem  [DEPTH];
  logic              m_busy [DEPTH];
  bit                m_clr;
  int                m_cnt;

  regfile_mp #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
    .NR(NR), .NW(NW), .ZERO_REG(1)
  ) dut (
    .clk(clk), .rst(rst),
    .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .wen(wen), .waddr(waddr), .wdata(wdata),
    .iss_en(iss_en), .iss_addr(iss_addr),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [ADDR_W-1:0] wa(input int j);
    return waddr[j*ADDR_W +: ADDR_W];
  endfunction

  function automatic logic [DATA_W-1:0] wd(input int j);
    return wdata[j*DATA_W +: DATA_W];
  endfunction

  function automatic logic [ADDR_W-1:0] ra(input int k);
    return raddr[k*ADDR_W +: ADDR_W];
  endfunction

  function automatic logic [DATA_W-1:0] rd(input int k);
    return rdata[k*DATA_W +: DATA_W];
  endfunction

  // Expected read value for the current (pre-edge) inputs
  function automatic logic [DATA_W-1:0] exp_rd(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    if (a == 0) return '0;
    v = m_mem[a];
`ifdef RF_BYPASS_EN
    if (!m_clr)
      for (int j = 0; j < NW; j++)
        if (wen[j] && wa(j) == a) v = wd(j);
`endif
    return v;
  endfunction

  function automatic logic exp_rb(input logic [ADDR_W-1:0] a);
    logic v;
    if (a == 0) return 1'b0;
    v = m_busy[a];
`ifdef RF_BYPASS_EN
    if (!m_clr)
      for (int j = 0; j < NW; j++)
        if (wen[j] && wa(j) == a) v = 1'b0;
`endif
    return v;
  endfunction

  task automatic set_raddr(input int k, input int a);
    raddr[k*ADDR_W +: ADDR_W] = ADDR_W'(a);
  endtask

  task automatic set_write(input int j, input int a, input logic [DATA_W-1:0] d);
    wen[j] = 1'b1;
    waddr[j*ADDR_W +: ADDR_W] = ADDR_W'(a);
    wdata[j*DATA_W +: DATA_W] = d;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; wen = '0; waddr = '0; wdata = '0;
    iss_en = 1'b0; iss_addr = '0; clr_req = 1'b0;
  endtask

  // One rising edge: the model takes the inputs held across the edge.
  task automatic tick();
    logic                 r  = rst;
    logic                 cr = clr_req;
    logic [NW-1:0]        we = wen;
    logic [NW*ADDR_W-1:0] wad = waddr;
    logic [NW*DATA_W-1:0] wdd = wdata;
    logic                 ie = iss_en;
    logic [ADDR_W-1:0]    ia = iss_addr;
    logic [ADDR_W-1:0]    a;
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < DEPTH; i++) begin m_mem[i] = '0; m_busy[i] = 1'b0; end
      m_clr = 1'b0; m_cnt = 0;
    end else if (m_clr) begin
      m_mem[m_cnt] = '0; m_busy[m_cnt] = 1'b0;
      if (m_cnt == DEPTH - 1) m_clr = 1'b0;
      m_cnt = (m_cnt + 1) % DEPTH;
    end else begin
      if (cr) begin m_clr = 1'b1; m_cnt = 0; end
      for (int j = 0; j < NW; j++) begin
        a = wad[j*ADDR_W +: ADDR_W];
        if (we[j] && a != 0) begin
          m_mem[a] = wdd[j*DATA_W +: DATA_W];
          m_busy[a] = 1'b0;
        end
      end
      if (ie && ia != 0) m_busy[ia] = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_cmp++;
    if (clr_busy !== 1'b0 || clr_done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: clr_busy=%b clr_done=%b expected 0 0", clr_busy, clr_done);
    end
    for (int a = 0; a < DEPTH; a++) begin
      for (int k = 0; k < NR; k++) set_raddr(k, (a + k) % DEPTH);
      #1;
      for (int k = 0; k < NR; k++) begin
        n_cmp++;
        if (rd(k) !== '0 || rbusy[k] !== 1'b0) begin
          n_err++;
          $display("FAIL reset_read: port %0d addr %0d got data %h busy %b expected 0 0",
                   k, ra(k), rd(k), rbusy[k]);
        end
      end
    end
  endtask

  task automatic test_collision();
    idle_inputs();
    set_write(0, 5, 32'h0000AAAA);
    set_write(1, 5, 32'h0000BBBB);
    tick();
    idle_inputs();
    set_raddr(0, 5);
    #1;
    n_cmp++;
    if (rd(0) !== 32'h0000BBBB) begin
      n_err++;
      $display("FAIL collision: reg5 got %h expected 0000bbbb", rd(0));
    end
    set_write(0, 0, 32'h0000FFFF);
    iss_en = 1'b1; iss_addr = '0;
    tick();
    idle_inputs();
    set_raddr(1, 0);
    #1;
    n_cmp++;
    if (rd(1) !== '0 || rbusy[1] !== 1'b0) begin
      n_err++;
      $display("FAIL zero_reg: got data %h busy %b expected 0 0", rd(1), rbusy[1]);
    end
  endtask

  task automatic test_scoreboard();
    idle_inputs();
    iss_en = 1'b1; iss_addr = 5'd7;
    tick();
    idle_inputs();
    set_raddr(1, 7);
    #1;
    n_cmp++;
    if (rbusy[1] !== 1'b1) begin
      n_err++;
      $display("FAIL sb_set: rbusy got %b expected 1", rbusy[1]);
    end
    set_write(0, 7, 32'h00000777);
    iss_en = 1'b1; iss_addr = 5'd7;
    tick();
    idle_inputs();
    #1;
    n_cmp++;
    if (rbusy[1] !== 1'b1 || rd(1) !== 32'h00000777) begin
      n_err++;
      $display("FAIL sb_set_wins: got busy %b data %h expected 1 00000777", rbusy[1], rd(1));
    end
    set_write(1, 7, 32'h00000778);
    tick();
    idle_inputs();
    #1;
    n_cmp++;
    if (rbusy[1] !== 1'b0 || rd(1) !== 32'h00000778) begin
      n_err++;
      $display("FAIL sb_release: got busy %b data %h expected 0 00000778", rbusy[1], rd(1));
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      idle_inputs();
      wen      = NW'($urandom);
      for (int j = 0; j < NW; j++) begin
        waddr[j*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, 7));
        wdata[j*DATA_W +: DATA_W] = $urandom;
      end
      iss_en   = $urandom_range(0, 1) == 1;
      iss_addr = ADDR_W'($urandom_range(0, 7));
      for (int k = 0; k < NR; k++) set_raddr(k, $urandom_range(0, 7));
      #1;
      for (int k = 0; k < NR; k++) begin
        n_cmp++;
        if (rd(k) !== exp_rd(ra(k)) || rbusy[k] !== exp_rb(ra(k))) begin
          n_err++;
          $display("FAIL random_read: cycle %0d port %0d addr %0d got %h/%b expected %h/%b",
                   c, k, ra(k), rd(k), rbusy[k], exp_rd(ra(k)), exp_rb(ra(k)));
        end
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_clear();
    int busy_cycles = 0;
    int done_cnt    = 0;
    int done_at     = 0;
    logic exp_done;
    idle_inputs();
    for (int i = 0; i < DEPTH / 2; i++) begin
      set_write(0, 2 * i,     $urandom | 32'h1);
      set_write(1, 2 * i + 1, $urandom | 32'h1);
      iss_en = 1'b1; iss_addr = ADDR_W'($urandom);
      tick();
    end
    idle_inputs();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      wen = NW'($urandom);
      waddr = (NW*ADDR_W)'($urandom);
      wdata = {$urandom, $urandom};
      iss_en = $urandom_range(0, 1) == 1;
      iss_addr = ADDR_W'($urandom);
      raddr = (NR*ADDR_W)'($urandom);
      #1;
      exp_done = m_clr && (m_cnt == DEPTH - 1);
      n_cmp++;
      if (clr_busy !== m_clr || clr_done !== exp_done) begin
        n_err++;
        $display("FAIL clear_ctrl: cycle %0d busy %b done %b expected %b %b",
                 c, clr_busy, clr_done, m_clr, exp_done);
      end
      for (int k = 0; k < NR; k++) begin
        n_cmp++;
        if (rd(k) !== exp_rd(ra(k)) || rbusy[k] !== exp_rb(ra(k))) begin
          n_err++;
          $display("FAIL clear_read: cycle %0d addr %0d got %h/%b expected %h/%b",
                   c, ra(k), rd(k), rbusy[k], exp_rd(ra(k)), exp_rb(ra(k)));
        end
      end
      if (clr_busy) busy_cycles++;
      if (clr_done) begin done_cnt++; done_at = c; end
      tick();
      if (!m_clr) break;
    end
    idle_inputs();
    #1;
    n_cmp++;
    if (busy_cycles != DEPTH || done_cnt != 1 || done_at != DEPTH) begin
      n_err++;
      $display("FAIL clear_timing: busy cycles %0d done pulses %0d at %0d expected %0d 1 %0d",
               busy_cycles, done_cnt, done_at, DEPTH, DEPTH);
    end
    for (int a = 0; a < DEPTH; a++) begin
      set_raddr(0, a);
      #1;
      n_cmp++;
      if (rd(0) !== '0 || rbusy[0] !== 1'b0) begin
        n_err++;
        $display("FAIL clear_result: addr %0d got %h/%b expected 0/0", a, rd(0), rbusy[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    clr_req = 1'b1;
    tick();
    for (int c = 0; c < 40; c++) begin
      tick();
      if (!m_clr) break;
    end
    n_cmp++;
    if (clr_busy !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_gap: clr_busy got %b expected 0", clr_busy);
    end
    tick();
    clr_req = 1'b0;
    #1;
    n_cmp++;
    if (clr_busy !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_restart: clr_busy got %b expected 1", clr_busy);
    end
    for (int c = 0; c < 40; c++) begin
      tick();
      if (!m_clr) break;
    end
    n_cmp++;
    if (clr_busy !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_end: clr_busy got %b expected 0", clr_busy);
    end
  endtask

  task automatic test_clear_reset();
    idle_inputs();
    for (int i = 0; i < DEPTH / 2; i++) begin
      set_write(0, 2 * i,     32'h100 + 32'(i));
      set_write(1, 2 * i + 1, 32'h200 + 32'(i));
      iss_en = 1'b1; iss_addr = ADDR_W'(31 - i);
      tick();
    end
    idle_inputs();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int c = 1; c <= 9; c++) tick();
    rst = 1'b1;
    #1;
    n_cmp++;
    if (clr_busy !== 1'b1 || clr_done !== 1'b0) begin
      n_err++;
      $display("FAIL rst_abort_pre: busy %b done %b expected 1 0", clr_busy, clr_done);
    end
    tick();
    rst = 1'b0;
    #1;
    n_cmp++;
    if (clr_busy !== 1'b0 || clr_done !== 1'b0) begin
      n_err++;
      $display("FAIL rst_abort_post: busy %b done %b expected 0 0", clr_busy, clr_done);
    end
    for (int a = 0; a < DEPTH; a++) begin
      set_raddr(2, a);
      #1;
      n_cmp++;
      if (rd(2) !== '0 || rbusy[2] !== 1'b0) begin
        n_err++;
        $display("FAIL rst_abort_regs: addr %0d got %h/%b expected 0/0", a, rd(2), rbusy[2]);
      end
    end
  endtask

  task automatic test_bypass();
    logic [DATA_W-1:0] exp_same;
    idle_inputs();
    set_write(0, 3, 32'h00005555);
    tick();
    idle_inputs();
    set_write(0, 3, 32'h00001234);
    iss_en = 1'b1; iss_addr = 5'd3;
    tick();
    idle_inputs();
    set_write(1, 3, 32'h00004321);
    set_raddr(2, 3);
    #1;
`ifdef RF_BYPASS_EN
    exp_same = 32'h00004321;
`else
    exp_same = 32'h00001234;
`endif
    n_cmp++;
    if (rd(2) !== exp_same) begin
      n_err++;
      $display("FAIL bypass_same: got %h expected %h", rd(2), exp_same);
    end
`ifdef RF_BYPASS_EN
    n_cmp++;
    if (rbusy[2] !== 1'b0) begin
      n_err++;
      $display("FAIL bypass_busy: got %b expected 0", rbusy[2]);
    end
`else
    n_cmp++;
    if (rbusy[2] !== 1'b1) begin
      n_err++;
      $display("FAIL nobypass_busy: got %b expected 1", rbusy[2]);
    end
`endif
    tick();
    idle_inputs();
    #1;
    n_cmp++;
    if (rd(2) !== 32'h00004321 || rbusy[2] !== 1'b0) begin
      n_err++;
      $display("FAIL bypass_next: got %h/%b expected 00004321/0", rd(2), rbusy[2]);
    end
  endtask

  initial begin
    idle_inputs();
    raddr = '0;
    m_clr = 1'b0;
    m_cnt = 0;
    for (int i = 0; i < DEPTH; i++) begin m_mem[i] = '0; m_busy[i] = 1'b0; end
    #3;
    test_reset();
    test_collision();
    test_scoreboard();
    test_random();
    test_bypass();
    test_clear();
    test_back_to_back();
    test_clear_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
